uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters; fixed at 4 for this release.
REQ-002 Parameter: TIMEOUT_CYCLES, 64, watchdog limit in BUSY; used only when UART_TX_ARB_TIMEOUT_EN is defined.
REQ-003 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: nrst  input  1  asynchronous, active-low reset.
REQ-005 Port: req  input  4  per-requester transmit request, level, held until done.
REQ-006 Port: req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-007 Port: gnt  output  4  one-hot, high for requester owning the UART from START through DONE.
REQ-008 Port: done  output  4  one-cycle pulse to owner when its frame completes or aborts.
REQ-009 Port: err  output  1  one-cycle pulse with done on watchdog abort; constant 0 without the macro.
REQ-010 Port: tx_ctrl  output  1  start strobe to UART_Tx.
REQ-011 Port: data_send  output  8  byte to UART_Tx, registered.
REQ-012 Port: transmit_ready  input  1  UART_Tx idle indication.
REQ-013 Port: success  input  1  UART_Tx frame-complete indication.

Function
REQ-014 FSM states IDLE, START, BUSY, DONE; all outputs registered.
REQ-015 IDLE: when transmit_ready=1 and req!=0, select winner round-robin, searching from last_owner+1 upward, wrapping 3->0; latch winner index, drive gnt, load data_send from req_data, go START.
REQ-016 IDLE with req=0 or transmit_ready=0: stay, gnt=0, tx_ctrl=0.
REQ-017 START: tx_ctrl=1 for exactly one cycle, clear busy_seen, go BUSY.
REQ-018 BUSY: set busy_seen on any cycle with transmit_ready=0; exit to DONE on first cycle with busy_seen=1, transmit_ready=1 and success=1.
REQ-019 DONE: done[owner]=1 for one cycle, last_owner<=owner, gnt=0 next cycle, go IDLE.
REQ-020 data_send stable from START until return to IDLE; req_data changes meanwhile are ignored.
REQ-021 Requester dropping req while granted does not abort the frame; done still pulses.
REQ-022 Minimum gap between two tx_ctrl strobes is 4 cycles (DONE, IDLE, START spacing); the same requester may win back-to-back only if no other req is high.
REQ-023 last_owner reset value 3, so requester 0 has first priority after reset.

Reset
REQ-024 nrst=0 forces immediately: state IDLE, gnt=0, done=0, err=0, tx_ctrl=0, data_send=0, busy_seen=0, watchdog=0, last_owner=3.
REQ-025 Reset mid-frame abandons the frame with no done pulse; arbitration restarts from IDLE after release.

Configuration
REQ-026 Macro UART_TX_ARB_TIMEOUT_EN defined: BUSY counts cycles from 0; at TIMEOUT_CYCLES without exit condition go DONE with done[owner]=1 and err=1; counter clears in START.
REQ-027 Macro undefined: no counter is synthesized, err is tied 0, BUSY waits indefinitely.

Verification
REQ-028 Reset then req=4'b0001, req_data[7:0]=8'hD3, UART model idle -> tx_ctrl one pulse, data_send=8'hD3, gnt=4'b0001, done[0] pulse after success.
REQ-029 req=4'b1111 held, bytes 8'h10/8'h21/8'h32/8'h43 -> grant order 0,1,2,3,0 with matching data_send each frame.
REQ-030 Owner 2 transmitting, req[0] and req[3] rise -> next grant 3, then 0.
REQ-031 nrst pulsed low during BUSY -> all outputs 0 at once, no done, next grant to requester 0.
REQ-032 Macro defined, TIMEOUT_CYCLES=16, UART model never asserts success -> done[owner] and err pulse 16 cycles after entering BUSY, FSM back in IDLE.
REQ-033 transmit_ready=0 with req=4'b0010 -> no tx_ctrl until transmit_ready=1, then START next cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter granting four requesters access to a single UART transmitter.
// Optional BUSY watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic                 tx_ctrl,
    output logic [7:0]           data_send,
    input  logic                 transmit_ready,
    input  logic                 success
);

    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [IW-1:0] owner;
    logic [IW-1:0] last_owner;
    logic [IW-1:0] winner;
    logic          found;
    logic          busy_seen;
    logic          exit_ok;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wd;
`endif

    // First active request strictly after last_owner, wrapping to 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req[(int'(last_owner) + i) % NUM_REQ]) begin
                winner = IW'((int'(last_owner) + i) % NUM_REQ);
                found  = 1'b1;
            end
        end
    end

    // busy_seen guarantees a stale success from the previous frame is ignored.
    assign exit_ok = busy_seen && transmit_ready && success;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            gnt        <= '0;
            done       <= '0;
            tx_ctrl    <= 1'b0;
            data_send  <= '0;
            busy_seen  <= 1'b0;
            owner      <= '0;
            last_owner <= IW'(NUM_REQ - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
            err        <= 1'b0;
            wd         <= '0;
`endif
        end else begin
            done    <= '0;
            tx_ctrl <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            err     <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    gnt <= '0;
                    if (transmit_ready && found) begin
                        owner     <= winner;
                        gnt       <= NUM_REQ'(1) << winner;
                        data_send <= req_data[{winner, 3'b000} +: 8];
                        tx_ctrl   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    busy_seen <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    wd        <= '0;
`endif
                    state     <= BUSY;
                end
                BUSY: begin
                    if (!transmit_ready) begin
                        busy_seen <= 1'b1;
                    end
                    if (exit_ok) begin
                        done  <= gnt;
                        state <= DONE;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (wd == WDW'(TIMEOUT_CYCLES - 1)) begin
                        done  <= gnt;
                        err   <= 1'b1;
                        state <= DONE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
`endif
                end
                DONE: begin
                    gnt        <= '0;
                    last_owner <= owner;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_TX_ARB_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a hand-driven UART_Tx model.
// Timeout vectors run only when UART_TX_ARB_TIMEOUT_EN is defined.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        nrst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        err;
    logic        tx_ctrl;
    logic [7:0]  data_send;
    logic        transmit_ready;
    logic        success;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ       (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .done          (done),
        .err           (err),
        .tx_ctrl       (tx_ctrl),
        .data_send     (data_send),
        .transmit_ready(transmit_ready),
        .success       (success)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tx(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_ctrl === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({tag, "_tx_timeout"}, 32'(tx_ctrl), 1);
    endtask

    // Entered on the negedge where tx_ctrl is high (DUT in START).
    task automatic body(input string tag, input int idx, input logic [7:0] b,
                        input logic [3:0] req_mid, input logic [3:0] req_post);
        logic [3:0]  oh;
        logic [31:0] saved;
        oh = 4'b0001 << idx;
        chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
        chk({tag, "_data"}, 32'(data_send), 32'(b));
        saved          = req_data;
        req_data       = ~saved;
        transmit_ready = 1'b0;
        req            = req_mid;
        @(negedge clk);
        chk({tag, "_tx_once"}, 32'(tx_ctrl), 0);
        repeat (2) @(negedge clk);
        chk({tag, "_no_early_done"}, 32'(done), 0);
        transmit_ready = 1'b1;
        success        = 1'b1;
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'(oh));
        chk({tag, "_gnt_at_done"}, 32'(gnt), 32'(oh));
        chk({tag, "_data_hold"}, 32'(data_send), 32'(b));
        chk({tag, "_err"}, 32'(err), 0);
        success  = 1'b0;
        req      = req_post;
        req_data = saved;
        @(negedge clk);
        chk({tag, "_done_clr"}, 32'(done), 0);
        chk({tag, "_gnt_clr"}, 32'(gnt), 0);
    endtask

    task automatic frame(input string tag, input int idx, input logic [7:0] b,
                         input logic [3:0] req_mid, input logic [3:0] req_post);
        bit ok;
        wait_tx(tag, ok);
        if (ok) body(tag, idx, b, req_mid, req_post);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        bit ok;
        nrst           = 1'b0;
        req            = 4'b0000;
        req_data       = 32'h0;
        transmit_ready = 1'b1;
        success        = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_tx", 32'(tx_ctrl), 0);
        chk("rst_data", 32'(data_send), 0);
        nrst = 1'b1;

        // Single requester, then same requester wins again when alone.
        req_data = 32'h0000_00D3;
        req      = 4'b0001;
        frame("t1", 0, 8'hD3, 4'b0001, 4'b0001);
        frame("t1b", 0, 8'hD3, 4'b0001, 4'b0000);

        // All requesting from reset: 0,1,2,3,0.
        do_reset();
        req_data = 32'h4332_2110;
        req      = 4'b1111;
        frame("rr0", 0, 8'h10, 4'b1111, 4'b1111);
        frame("rr1", 1, 8'h21, 4'b1111, 4'b1111);
        frame("rr2", 2, 8'h32, 4'b1111, 4'b1111);
        frame("rr3", 3, 8'h43, 4'b1111, 4'b1111);
        frame("rr4", 0, 8'h10, 4'b1111, 4'b0000);

        // Owner 2 busy while 0 and 3 rise: 3 then 0.
        req = 4'b0100;
        frame("t3a", 2, 8'h32, 4'b1101, 4'b1001);
        frame("t3b", 3, 8'h43, 4'b1001, 4'b0001);
        frame("t3c", 0, 8'h10, 4'b0001, 4'b0000);

        // Requester drops req mid-frame; done still pulses.
        req = 4'b0010;
        frame("t4", 1, 8'h21, 4'b0000, 4'b0000);

        // Reset during BUSY of owner 2.
        req = 4'b0100;
        wait_tx("t5", ok);
        transmit_ready = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 0);
        chk("t5_rst_tx", 32'(tx_ctrl), 0);
        chk("t5_rst_data", 32'(data_send), 0);
        chk("t5_rst_done", 32'(done), 0);
        req            = 4'b1111;
        transmit_ready = 1'b1;
        success        = 1'b1;
        @(negedge clk);
        chk("t5_rst_nodone", 32'(done), 0);
        success = 1'b0;
        nrst    = 1'b1;
        frame("t5", 0, 8'h10, 4'b0000, 4'b0000);

        // UART not ready holds off the start.
        transmit_ready = 1'b0;
        req            = 4'b0010;
        repeat (5) @(negedge clk);
        chk("t6_hold_tx", 32'(tx_ctrl), 0);
        chk("t6_hold_gnt", 32'(gnt), 0);
        transmit_ready = 1'b1;
        @(negedge clk);
        chk("t6_start", 32'(tx_ctrl), 1);
        body("t6", 1, 8'h21, 4'b0000, 4'b0000);

`ifdef UART_TX_ARB_TIMEOUT_EN
        // Watchdog: success never arrives.
        req = 4'b0100;
        wait_tx("t7", ok);
        transmit_ready = 1'b0;
        req            = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t7_wait", 32'(done), 0);
        end
        @(negedge clk);
        chk("t7_done", 32'(done), 32'h4);
        chk("t7_err", 32'(err), 1);
        @(negedge clk);
        chk("t7_done_clr", 32'(done), 0);
        chk("t7_err_clr", 32'(err), 0);
        chk("t7_gnt_clr", 32'(gnt), 0);
        transmit_ready = 1'b1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
